// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the car-park occupancy and entry-barrier controller:
// default geometry, gate FSM state encodings, counter event decode and the
// gate timer width helper.
package parking_gate_ctrl_pkg;

  // Default car-park geometry and gate timing.
  localparam int DEF_CAPACITY     = 15;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_GATE_TIMEOUT = 100;
  localparam int DEF_HOLD_CYC     = 10;

  // Entry-barrier FSM states. The encodings are shared with the sensor FSM
  // and the display logic, so they are pinned explicitly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_HOLD = 2'd2
  } gate_state_e;

  // What the occupancy counter does with this cycle's sensor pulses.
  typedef enum logic [2:0] {
    EV_NONE = 3'd0,  // no pulse, or entry and exit cancel out
    EV_INC  = 3'd1,  // a car entered and there was room
    EV_DEC  = 3'd2,  // a car left and the park was not empty
    EV_OVF  = 3'd3,  // a car entered while full: count holds, flag it
    EV_UNF  = 3'd4   // a car left while empty: count holds, flag it
  } cnt_event_e;

  // Timer must cover both the OPEN timeout and the HOLD period. Its exit
  // compares fire at N-1, so $clog2 of the larger limit is enough; clamp to
  // one bit so a degenerate limit of 1 still gives a legal vector.
  function automatic int timer_width(input int gate_timeout, input int hold_cyc);
    int max_lim;
    int w;
    max_lim = (gate_timeout > hold_cyc) ? gate_timeout : hold_cyc;
    w       = $clog2(max_lim);
    return (w < 1) ? 1 : w;
  endfunction

  // Decode the sensor pulses against the current full/empty state.
  function automatic cnt_event_e classify(input logic up, input logic dn,
                                          input logic is_full, input logic is_empty);
    cnt_event_e ev;
    ev = EV_NONE;
    if (up && !dn) begin
      ev = is_full ? EV_OVF : EV_INC;
    end else if (dn && !up) begin
      ev = is_empty ? EV_UNF : EV_DEC;
    end
    return ev;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_occ_counter.sv
// Saturating occupancy counter. Counts car entries/exits from the sensor
// pulses, decodes full/empty straight from the count register and keeps
// sticky overflow/underflow flags that clear on request.
module occ_counter
  import parking_gate_ctrl_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_err_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full_w, empty_w;
  cnt_event_e       ev_w;

  // full/empty come straight off the count register, so they track it with
  // no extra cycle of delay.
  assign full_w  = (count_q == CAP_VAL);
  assign empty_w = (count_q == '0);
  assign ev_w    = classify(inc_i, dec_i, full_w, empty_w);

  // Next count and next error flags from this cycle's event.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    count_d = count_q;
    case (ev_w)
      EV_INC:  count_d = count_q + CNT_W'(1);
      EV_DEC:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A fresh error in the same cycle as clr_err wins: the flag stays set.
    ovf_d = (ev_w == EV_OVF) || (ovf_q && !clr_err_i);
    unf_d = (ev_w == EV_UNF) || (unf_q && !clr_err_i);
  end

  // Count and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, regardless of statement order.
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o     = count_q;
  assign full_o      = full_w;
  assign empty_o     = empty_w;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park occupancy and entry-barrier controller. The occupancy counter
// follows the sensor pulses in every gate state; the barrier FSM opens on a
// waiting car (unless full), waits for the car to enter, holds the barrier
// open for a fixed time, then closes. An OPEN with no car aborts after a
// timeout and reports it with a one-cycle pulse.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT,
  parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             sumar,
  input  logic             restar,
  input  logic             clr_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             timeout_p,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int                   TIMER_W   = timer_width(GATE_TIMEOUT, HOLD_CYC);
  localparam logic [TIMER_W-1:0]   OPEN_LAST = TIMER_W'(GATE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]   HOLD_LAST = TIMER_W'(HOLD_CYC - 1);

  gate_state_e        state_q;
  logic [TIMER_W-1:0] timer_q;
  logic               gate_open_q;
  logic               timeout_p_q;
  logic               full_w;

  // Occupancy: the sensors are the authority, so counting runs in every
  // gate state and restar never touches the barrier.
  occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk         (clk),
    .rst_n       (rst),
    .inc_i       (sumar),
    .dec_i       (restar),
    .clr_err_i   (clr_err),
    .count_o     (count),
    .full_o      (full_w),
    .empty_o     (empty),
    .overflow_o  (overflow_err),
    .underflow_o (underflow_err)
  );

  assign full = full_w;

  // Barrier FSM with its timer and registered motor/timeout outputs. The
  // asynchronous reset drops gate_open at once, even mid-OPEN or mid-HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      timeout_p_q <= 1'b0;
    end else begin
      timeout_p_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A waiting car is ignored while the park is full.
          if (req_in && !full_w) begin
            state_q     <= S_OPEN;
            timer_q     <= '0;
            gate_open_q <= 1'b1;
          end
        end
        S_OPEN: begin
          if (sumar) begin
            state_q <= S_HOLD;
            timer_q <= '0;
          end else if (timer_q == OPEN_LAST) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
            timeout_p_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        S_HOLD: begin
          // A second sumar here only counts; the hold is not restarted.
          if (timer_q == HOLD_LAST) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          timer_q     <= '0;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

  assign gate_open = gate_open_q;
  assign timeout_p = timeout_p_q;

endmodule
